spi_clkgen: RTL and testbench
=============================

Name: spi_clkgen

Overview:
- Parametrised SPI serial-clock generator. It replaces the fixed-frequency SPI PLL output with a runtime-programmable integer divider of refclk.
- Produces SCLK with selectable CPOL/CPHA, one-cycle sample/shift strobes for the SPI shift engine, clean start/stop on idle polarity, and a locked indication after divider changes.
- Sits between the board reference clock and the SPI master datapath. It runs entirely in the refclk domain with no generated clock nets.

Parameters:
- DIV_W, 8, width of the divider value; SCLK period = 2*(div+1) refclk cycles.
- DEFAULT_DIV, 1, divider value loaded at reset; 50 MHz refclk gives 12.5 MHz.
- LOCK_CYCLES, 16, refclk cycles from divider apply until locked asserts; must be ≥1.

Ports:
- refclk, in, 1, sole clock; all logic is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, run request (level).
- div_in, in, DIV_W, new divider value.
- div_load, in, 1, one-cycle strobe that captures div_in.
- cpol, in, 1, clock polarity; sampled only while idle.
- cpha, in, 1, clock phase; sampled only while idle.
- sclk, out, 1, registered serial clock.
- lead_stb, out, 1, high in the cycle sclk makes its leading edge.
- trail_stb, out, 1, high in the cycle sclk makes its trailing edge.
- sample_stb, out, 1, equals lead_stb if cpha=0, else trail_stb.
- shift_stb, out, 1, equals trail_stb if cpha=0, else lead_stb.
- busy, out, 1, generator running.
- locked, out, 1, divider stable for LOCK_CYCLES.

Behaviour:
- Reset (async on rst_n low):
  - sclk=0, all strobes=0, busy=0, locked=0.
  - Internal state: cnt=0, phase=0, pend_valid=0, div_act=DEFAULT_DIV, cpol_q=0, cpha_q=0.
  - Lock counter starts at 0 on rst_n release. locked rises on the LOCK_CYCLES-th refclk edge after release.
- Outputs: sclk = cpol_q XOR phase, registered. All outputs are registered; there is no combinational path from inputs to outputs.
- State machine:
  - IDLE:
    - cpol_q/cpha_q track cpol/cpha each cycle; sclk follows cpol_q.
    - If en is sampled 1, go to RUN: busy=1 next cycle, cnt=0, phase=0.
  - RUN:
    - cnt increments each cycle. When cnt==div_act: cnt←0, phase toggles, and the matching strobe pulses in the same cycle sclk changes.
    - phase 0→1 is the leading edge; phase 1→0 is the trailing edge.
    - First leading edge occurs div_act+1 cycles after busy rises.
    - cpol/cpha inputs are ignored in RUN.
  - Stop:
    - en is evaluated only at trailing edges.
    - If en=0 at a trailing edge, go to IDLE: busy=0 in the same cycle sclk returns to idle level.
    - Consequence: at least one full SCLK period is emitted per start, and there are never partial pulses.
- Divider update:
  - div_load captures div_in into pending and sets pend_valid. A second load before apply overwrites pending (last value wins).
  - Apply point in IDLE: the cycle after capture.
  - Apply point in RUN: at the next trailing edge. cnt restarts from 0 with the new div_act. The next half-period uses the new value.
  - On apply: pend_valid←0, locked←0, lock counter←0. locked←1 after LOCK_CYCLES further cycles.
  - div_load coincident with an apply point: the new value is captured and applied at the following apply point.
  - locked does not gate operation; it is status only.
- Boundaries:
  - div=0 gives sclk = refclk/2 with strobes every cycle.
  - div=all-ones gives max period 2^(DIV_W+1) cycles.
  - cnt never exceeds div_act; no wrap beyond the compare value.
- en and a stop edge in the same cycle: en is sampled at the trailing edge; en=1 keeps running with no gap.
- Reset mid-run: immediately returns to reset values. No strobe is emitted and sclk goes low asynchronously.

Test Plan:
- Reset release, DEFAULT_DIV=1, cpol=0, cpha=0, en=1 → busy at cycle 1; sclk first rise 2 cycles later; period 4 cycles; lead_stb/sample_stb on rises; locked high 16 cycles after release.
- cpol=1, cpha=1, div_in=0 loaded while idle, en=1 for 10 cycles then 0 → sclk idles 1, toggles every cycle; sample_stb on rising (trailing) edges; stops high after a trailing edge with busy=0 in the same cycle.
- Run at div=3, pulse div_load with 7 mid-high-phase → half-period stays 4 until trailing edge, then 8; locked drops at apply and returns 16 cycles later.
- en high for a single cycle at div=2 → exactly one full SCLK period (6 cycles), one lead_stb, one trail_stb, then idle.
- Toggle cpol while busy → sclk polarity unchanged until idle; the new polarity appears the cycle after stop.
- Assert rst_n low mid-high-phase → sclk, busy, strobes and locked all go 0 asynchronously; after release, divider is back to DEFAULT_DIV.

Source files
------------

// File: rtl/spi_clkgen.sv
// spi_clkgen: runtime-programmable SPI serial-clock generator.
// Divides refclk by 2*(div+1), emits registered SCLK with CPOL/CPHA and
// single-cycle edge strobes, and reports divider lock after updates.
module spi_clkgen #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    input  logic             cpol,
    input  logic             cpha,
    output logic             sclk,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             busy,
    output logic             locked
);

    localparam int unsigned      LockW    = $clog2(LOCK_CYCLES) + 1;
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [DIV_W-1:0]   div_act_q, div_act_d;
    logic [DIV_W-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
    logic               locked_q, locked_d;
    logic               sclk_q, sclk_d;
    logic               lead_q, lead_d;
    logic               trail_q, trail_d;
    logic               sample_q, sample_d;
    logic               shift_q, shift_d;
    logic               busy_q, busy_d;
    logic               apply;

    // Next-state: idle/run sequencing, edge generation, divider apply and lock tracking.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        div_act_d    = div_act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        lock_cnt_d   = lock_cnt_q;
        locked_d     = locked_q;
        lead_d       = 1'b0;
        trail_d      = 1'b0;
        apply        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpol_d = cpol;
                cpha_d = cpha;
                apply  = pend_valid_q;
                if (en) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                end
            end
            StRun: begin
                if (cnt_q == div_act_q) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        // Trailing edge: the only point where stop and divider apply happen,
                        // so every start yields whole SCLK periods.
                        trail_d = 1'b1;
                        apply   = pend_valid_q;
                        if (!en) begin
                            state_d = StIdle;
                        end
                    end else begin
                        lead_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (apply) begin
            div_act_d    = pend_q;
            pend_valid_d = 1'b0;
        end
        // A load coincident with apply is kept pending for the next apply point.
        if (div_load) begin
            pend_d       = div_in;
            pend_valid_d = 1'b1;
        end

        if (apply) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (!locked_q) begin
            if (lock_cnt_q == LockLast) begin
                locked_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end

        // CPHA is frozen for the whole run, so the strobe mapping is stable.
        sclk_d   = cpol_d ^ phase_d;
        busy_d   = (state_d == StRun);
        sample_d = cpha_q ? trail_d : lead_d;
        shift_d  = cpha_q ? lead_d : trail_d;
    end

    // State and registered outputs; async reset forces every output low.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            div_act_q    <= DIV_W'(DEFAULT_DIV);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
            sclk_q       <= 1'b0;
            lead_q       <= 1'b0;
            trail_q      <= 1'b0;
            sample_q     <= 1'b0;
            shift_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            div_act_q    <= div_act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            lock_cnt_q   <= lock_cnt_d;
            locked_q     <= locked_d;
            sclk_q       <= sclk_d;
            lead_q       <= lead_d;
            trail_q      <= trail_d;
            sample_q     <= sample_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
        end
    end

    assign sclk       = sclk_q;
    assign lead_stb   = lead_q;
    assign trail_stb  = trail_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;
    assign busy       = busy_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_spi_clkgen.sv
// Self-checking bench for spi_clkgen: vector table plus multi-cycle sequences.
module tb_spi_clkgen;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       cpol;
    logic       cpha;
    logic       sclk, lead_stb, trail_stb, sample_stb, shift_stb, busy, locked;

    int n_checks = 0;
    int n_errors = 0;

    // Expected bits: {sclk, lead, trail, sample, shift, busy, locked}
    typedef struct {
        logic       en;
        logic [7:0] div_in;
        logic       div_load;
        logic       cpol;
        logic       cpha;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    spi_clkgen #(
        .DIV_W      (8),
        .DEFAULT_DIV(1),
        .LOCK_CYCLES(16)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .div_load  (div_load),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sample_stb(sample_stb),
        .shift_stb (shift_stb),
        .busy      (busy),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic e, input logic [7:0] d, input logic ld,
                                input logic pol, input logic pha, input logic [6:0] x);
        vec_t v;
        v.en = e; v.div_in = d; v.div_load = ld; v.cpol = pol; v.cpha = pha; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    function automatic logic [6:0] outs();
        return {sclk, lead_stb, trail_stb, sample_stb, shift_stb, busy, locked};
    endfunction

    initial begin
        int busy_n, lead_n, trail_n, high_n, samp_n;
        logic e_sclk;

        // Default divider, mode 0, run from release; stop at the 21st edge.
        add(1, 0, 0, 0, 0, 7'b0000010); add(1, 0, 0, 0, 0, 7'b0000010);
        add(1, 0, 0, 0, 0, 7'b1101010); add(1, 0, 0, 0, 0, 7'b1000010);
        add(1, 0, 0, 0, 0, 7'b0010110); add(1, 0, 0, 0, 0, 7'b0000010);
        add(1, 0, 0, 0, 0, 7'b1101010); add(1, 0, 0, 0, 0, 7'b1000010);
        add(1, 0, 0, 0, 0, 7'b0010110); add(1, 0, 0, 0, 0, 7'b0000010);
        add(1, 0, 0, 0, 0, 7'b1101010); add(1, 0, 0, 0, 0, 7'b1000010);
        add(1, 0, 0, 0, 0, 7'b0010110); add(1, 0, 0, 0, 0, 7'b0000010);
        add(1, 0, 0, 0, 0, 7'b1101010); add(1, 0, 0, 0, 0, 7'b1000011);
        add(1, 0, 0, 0, 0, 7'b0010111);
        add(0, 0, 0, 0, 0, 7'b0000011); add(0, 0, 0, 0, 0, 7'b1101011);
        add(0, 0, 0, 0, 0, 7'b1000011); add(0, 0, 0, 0, 0, 7'b0010101);
        add(0, 0, 0, 0, 0, 7'b0000001);
        // Mode 3, div=0 loaded while idle, en high for 10 cycles.
        add(0, 0, 1, 1, 1, 7'b1000001); add(0, 0, 0, 1, 1, 7'b1000000);
        add(1, 0, 0, 1, 1, 7'b1000010); add(1, 0, 0, 1, 1, 7'b0100110);
        add(1, 0, 0, 1, 1, 7'b1011010); add(1, 0, 0, 1, 1, 7'b0100110);
        add(1, 0, 0, 1, 1, 7'b1011010); add(1, 0, 0, 1, 1, 7'b0100110);
        add(1, 0, 0, 1, 1, 7'b1011010); add(1, 0, 0, 1, 1, 7'b0100110);
        add(1, 0, 0, 1, 1, 7'b1011010); add(1, 0, 0, 1, 1, 7'b0100110);
        add(0, 0, 0, 1, 1, 7'b1011000); add(0, 0, 0, 1, 1, 7'b1000000);
        add(0, 0, 0, 1, 1, 7'b1000000); add(0, 0, 0, 1, 1, 7'b1000000);
        add(0, 0, 0, 1, 1, 7'b1000000); add(0, 0, 0, 1, 1, 7'b1000001);

        rst_n = 1'b0; en = 1'b1; div_in = '0; div_load = 1'b0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) cycle();
        chk("reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            en = vecs[k].en; div_in = vecs[k].div_in; div_load = vecs[k].div_load;
            cpol = vecs[k].cpol; cpha = vecs[k].cpha;
            cycle();
            chk($sformatf("vec[%0d]", k + 1), 32'(outs()), 32'(vecs[k].exp));
        end

        // Divider change 3 -> 7 loaded during the high phase.
        en = 1'b0; cpol = 1'b0; cpha = 1'b0; div_in = 8'd3; div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        cycle();
        chk("lock_drop_idle_apply", 32'(locked), 32'h0);
        repeat (16) cycle();
        chk("lock_return_idle", 32'(locked), 32'h1);
        en = 1'b1;
        cycle();
        chk("div3_busy", 32'(busy), 32'h1);
        repeat (3) cycle();
        chk("div3_low_before_lead", 32'(sclk), 32'h0);
        cycle();
        chk("div3_lead", 32'({sclk, lead_stb}), 32'h3);
        for (int i = 1; i <= 20; i++) begin
            div_load = (i == 1);
            div_in   = 8'd7;
            cycle();
            e_sclk = (i <= 3) || (i >= 12 && i <= 19);
            chk($sformatf("div7_sclk[%0d]", i), 32'(sclk), 32'(e_sclk));
            chk($sformatf("div7_lead[%0d]", i), 32'(lead_stb), 32'(i == 12));
            chk($sformatf("div7_trail[%0d]", i), 32'(trail_stb), 32'(i == 4 || i == 20));
            chk($sformatf("div7_locked[%0d]", i), 32'(locked), 32'(i < 4 || i >= 20));
        end
        div_load = 1'b0;
        en = 1'b0;
        for (int n = 0; n < 40 && busy; n++) cycle();
        chk("div7_stop", 32'({busy, sclk}), 32'h0);

        // Single-cycle en at div=2: one whole period.
        div_in = 8'd2; div_load = 1'b1;
        cycle();
        div_load = 1'b0;
        cycle();
        busy_n = 0; lead_n = 0; trail_n = 0; high_n = 0; samp_n = 0;
        for (int i = 0; i < 14; i++) begin
            en = (i == 0);
            cycle();
            busy_n  += int'(busy);
            lead_n  += int'(lead_stb);
            trail_n += int'(trail_stb);
            high_n  += int'(sclk);
            samp_n  += int'(sample_stb);
        end
        chk("one_shot_busy_cycles", 32'(busy_n), 32'd6);
        chk("one_shot_leads", 32'(lead_n), 32'd1);
        chk("one_shot_trails", 32'(trail_n), 32'd1);
        chk("one_shot_high_cycles", 32'(high_n), 32'd3);
        chk("one_shot_samples", 32'(samp_n), 32'd1);

        // CPOL change while busy takes effect only after stop.
        for (int i = 0; i <= 7; i++) begin
            en   = (i == 0);
            cpol = (i != 0);
            cycle();
            e_sclk = (i >= 3 && i <= 5) || (i == 7);
            chk($sformatf("cpol_hold_sclk[%0d]", i), 32'(sclk), 32'(e_sclk));
            chk($sformatf("cpol_hold_busy[%0d]", i), 32'(busy), 32'(i <= 5));
        end

        // Reset asserted in the middle of the high phase.
        cpol = 1'b0; en = 1'b0;
        cycle();
        chk("pre_reset_idle_low", 32'({sclk, locked}), 32'h1);
        en = 1'b1;
        cycle();
        repeat (3) cycle();
        chk("pre_reset_high_phase", 32'({sclk, busy}), 32'h3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(outs()), 32'h0);
        cycle();
        chk("reset_held_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk($sformatf("post_reset_sclk[%0d]", i), 32'(sclk), 32'(i == 3));
            chk($sformatf("post_reset_lead[%0d]", i), 32'(lead_stb), 32'(i == 3));
            chk($sformatf("post_reset_busy[%0d]", i), 32'(busy), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
